// File: rtl/lcd_pkg.sv
// Shared LCD controller package: read-FSM state encoding, 50 MHz timing constants
// shared with the write-side FSMs, and RS select values.
package lcd_pkg;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_SETUP,
      RD_E_HI1,
      RD_GAP,
      RD_E_HI2,
      RD_HOLD,
      RD_POLL_WAIT,
      RD_DONE
   } lcd_rd_state_e;

   localparam int unsigned LCD_SETUP_CYC      = 2;
   localparam int unsigned LCD_E_HIGH_CYC     = 12;
   localparam int unsigned LCD_NIBBLE_GAP_CYC = 50;
   localparam int unsigned LCD_HOLD_CYC       = 2;
   localparam int unsigned LCD_POLL_GAP_CYC   = 50;

   localparam logic LCD_RS_CMD  = 1'b0;
   localparam logic LCD_RS_DATA = 1'b1;

   function automatic logic lcd_cnt_last(input logic [5:0] cnt, input int unsigned len);
      return cnt == 6'(len - 1);
   endfunction

endpackage

// File: rtl/lcd_read_fsm_if.sv
// Request/response and LCD pin bundle for the read-side controller.
interface lcd_read_fsm_if;
   logic       read_enable;
   logic       read_rs;
   logic       read_poll;
   logic [3:0] lcd_db_in;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       bus_req;
   logic [7:0] read_data;
   logic       read_done;

   modport master (
      output read_enable, read_rs, read_poll, lcd_db_in,
      input  lcd_e, lcd_rs, lcd_rw, bus_req, read_data, read_done
   );

   modport slave (
      input  read_enable, read_rs, read_poll, lcd_db_in,
      output lcd_e, lcd_rs, lcd_rw, bus_req, read_data, read_done
   );
endinterface

// File: rtl/lcd_read_fsm.sv
// HD44780 4-bit read cycle controller: two E-strobed nibble reads assembled into a byte.
// Optional busy-flag polling is compiled in with `define LCD_BUSY_POLL_EN.
module lcd_read_fsm
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC      = LCD_SETUP_CYC,
   parameter int unsigned E_HIGH_CYC     = LCD_E_HIGH_CYC,
   parameter int unsigned NIBBLE_GAP_CYC = LCD_NIBBLE_GAP_CYC,
   parameter int unsigned HOLD_CYC       = LCD_HOLD_CYC,
   parameter int unsigned POLL_GAP_CYC   = LCD_POLL_GAP_CYC
) (
   input  logic           clk,
   input  logic           reset,
   lcd_read_fsm_if.slave  bus
);

   lcd_rd_state_e state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          lcd_e_q, lcd_e_d;
   logic          lcd_rs_q, lcd_rs_d;
   logic          lcd_rw_q, lcd_rw_d;
   logic          bus_req_q, bus_req_d;
   logic          done_q, done_d;

`ifdef LCD_BUSY_POLL_EN
   logic          poll_q, poll_d;
`else
   logic          unused_poll;
   assign unused_poll = bus.read_poll;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 6'd1;
      rs_d    = rs_q;
      data_d  = data_q;
`ifdef LCD_BUSY_POLL_EN
      poll_d  = poll_q;
`endif

      unique case (state_q)
         RD_IDLE: begin
            cnt_d = '0;
            if (bus.read_enable) begin
               rs_d    = bus.read_rs;
`ifdef LCD_BUSY_POLL_EN
               poll_d  = bus.read_poll;
`endif
               state_d = RD_SETUP;
            end
         end
         RD_SETUP: if (lcd_cnt_last(cnt_q, SETUP_CYC)) state_d = RD_E_HI1;
         RD_E_HI1: if (lcd_cnt_last(cnt_q, E_HIGH_CYC)) begin
            data_d[7:4] = bus.lcd_db_in;
            state_d     = RD_GAP;
         end
         RD_GAP:   if (lcd_cnt_last(cnt_q, NIBBLE_GAP_CYC)) state_d = RD_E_HI2;
         RD_E_HI2: if (lcd_cnt_last(cnt_q, E_HIGH_CYC)) begin
            data_d[3:0] = bus.lcd_db_in;
            state_d     = RD_HOLD;
         end
         RD_HOLD: if (lcd_cnt_last(cnt_q, HOLD_CYC)) begin
            state_d = RD_DONE;
`ifdef LCD_BUSY_POLL_EN
            // data_q[7] already holds this read's busy flag from the first nibble
            if (poll_q && rs_q == LCD_RS_CMD && data_q[7]) state_d = RD_POLL_WAIT;
`endif
         end
         RD_POLL_WAIT: if (lcd_cnt_last(cnt_q, POLL_GAP_CYC)) state_d = RD_SETUP;
         RD_DONE:  state_d = RD_IDLE;
         default:  state_d = RD_IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;

      // Outputs are registered from the next state so pins line up with the state cycle
      lcd_e_d   = (state_d == RD_E_HI1) || (state_d == RD_E_HI2);
      lcd_rw_d  = (state_d != RD_IDLE) && (state_d != RD_DONE);
      lcd_rs_d  = lcd_rw_d & rs_d;
      bus_req_d = (state_d != RD_IDLE);
      done_d    = (state_d == RD_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= RD_IDLE;
         cnt_q     <= '0;
         rs_q      <= 1'b0;
         data_q    <= '0;
         lcd_e_q   <= 1'b0;
         lcd_rs_q  <= 1'b0;
         lcd_rw_q  <= 1'b0;
         bus_req_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
         poll_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
         lcd_e_q   <= lcd_e_d;
         lcd_rs_q  <= lcd_rs_d;
         lcd_rw_q  <= lcd_rw_d;
         bus_req_q <= bus_req_d;
         done_q    <= done_d;
`ifdef LCD_BUSY_POLL_EN
         poll_q    <= poll_d;
`endif
      end
   end

   assign bus.lcd_e     = lcd_e_q;
   assign bus.lcd_rs    = lcd_rs_q;
   assign bus.lcd_rw    = lcd_rw_q;
   assign bus.bus_req   = bus_req_q;
   assign bus.read_data = data_q;
   assign bus.read_done = done_q;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Self-checking bench for lcd_read_fsm: per-cycle pin/timing model derived from the
// read-cycle timetable, randomized pad data and request noise outside IDLE.
module tb_lcd_read_fsm;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] exp_rd;
   logic [3:0] hi_n [3];
   logic [3:0] lo_n [3];

   lcd_read_fsm_if bus ();

   lcd_read_fsm #(
      .SETUP_CYC      (2),
      .E_HIGH_CYC     (12),
      .NIBBLE_GAP_CYC (50),
      .HOLD_CYC       (2),
      .POLL_GAP_CYC   (50)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   // Caller is positioned at cycle 0 (IDLE). Returns positioned at the first IDLE
   // cycle after the read (or after an abort), with that cycle already checked.
   task automatic run_read(input logic rs, input logic poll, input bit keep_en,
                           input int abort_at, input int abort_len, output int done_cycle);
      int  n, last;
      bit  poll_on;
      logic exp_e;
      poll_on = 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_on = poll && (rs == 1'b0);
`endif
      n = 1;
      while (poll_on && n < 3 && hi_n[n-1][3]) n++;
      last = 128 * (n - 1) + 79;
      done_cycle = -1;

      bus.read_enable = 1'b1;
      bus.read_rs     = rs;
      bus.read_poll   = poll;
      bus.lcd_db_in   = 4'($urandom);
      @(posedge clk); #1;

      for (int c = 1; c <= last + 1; c++) begin
         int j, o;
         j = (c - 1) / 128;
         if (j > n - 1) j = n - 1;
         o = c - 128 * j;

         if (abort_at != 0 && c > abort_at) begin
            checks += 5;
            if (bus.lcd_e !== 1'b0)     begin errors++; $display("FAIL abort_e cycle %0d: got %b expected 0", c, bus.lcd_e); end
            if (bus.lcd_rw !== 1'b0)    begin errors++; $display("FAIL abort_rw cycle %0d: got %b expected 0", c, bus.lcd_rw); end
            if (bus.bus_req !== 1'b0)   begin errors++; $display("FAIL abort_bus_req cycle %0d: got %b expected 0", c, bus.bus_req); end
            if (bus.read_done !== 1'b0) begin errors++; $display("FAIL abort_done cycle %0d: got %b expected 0", c, bus.read_done); end
            if (bus.read_data !== 8'h00) begin errors++; $display("FAIL abort_data cycle %0d: got %h expected 00", c, bus.read_data); end
            if (c == abort_at + abort_len) begin
               reset = 1'b1;
               @(posedge clk); #1;
               checks += 2;
               if (bus.bus_req !== 1'b0)   begin errors++; $display("FAIL post_abort_idle: bus_req got %b expected 0", bus.bus_req); end
               if (bus.read_done !== 1'b0) begin errors++; $display("FAIL post_abort_done: got %b expected 0", bus.read_done); end
               return;
            end
            @(posedge clk); #1;
            continue;
         end

         if (o == 15) exp_rd[7:4] = hi_n[j];
         if (o == 77) exp_rd[3:0] = lo_n[j];

         checks += 3;
         if (bus.read_data !== exp_rd) begin errors++; $display("FAIL read_data cycle %0d: got %h expected %h", c, bus.read_data, exp_rd); end
         if (c == last + 1) begin
            if (bus.bus_req !== 1'b0)   begin errors++; $display("FAIL idle_bus_req cycle %0d: got %b expected 0", c, bus.bus_req); end
            if (bus.read_done !== 1'b0) begin errors++; $display("FAIL idle_done cycle %0d: got %b expected 0", c, bus.read_done); end
            checks += 3;
            if (bus.lcd_e !== 1'b0)  begin errors++; $display("FAIL idle_e cycle %0d: got %b expected 0", c, bus.lcd_e); end
            if (bus.lcd_rw !== 1'b0) begin errors++; $display("FAIL idle_rw cycle %0d: got %b expected 0", c, bus.lcd_rw); end
            if (bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL idle_rs cycle %0d: got %b expected 0", c, bus.lcd_rs); end
            break;
         end
         if (bus.bus_req !== 1'b1) begin errors++; $display("FAIL busy_bus_req cycle %0d: got %b expected 1", c, bus.bus_req); end
         if (c == last) begin
            if (bus.read_done !== 1'b1) begin errors++; $display("FAIL done_pulse cycle %0d: got %b expected 1", c, bus.read_done); end
            else done_cycle = c;
            checks++;
            if (bus.lcd_e !== 1'b0) begin errors++; $display("FAIL done_e cycle %0d: got %b expected 0", c, bus.lcd_e); end
         end else begin
            if (bus.read_done !== 1'b0) begin errors++; $display("FAIL early_done cycle %0d: got %b expected 0", c, bus.read_done); end
            exp_e = (o >= 3 && o <= 14) || (o >= 65 && o <= 76);
            checks++;
            if (bus.lcd_e !== exp_e) begin errors++; $display("FAIL lcd_e cycle %0d: got %b expected %b", c, bus.lcd_e, exp_e); end
            if (o <= 78) begin
               checks += 2;
               if (bus.lcd_rw !== 1'b1) begin errors++; $display("FAIL lcd_rw cycle %0d: got %b expected 1", c, bus.lcd_rw); end
               if (bus.lcd_rs !== rs)   begin errors++; $display("FAIL lcd_rs cycle %0d: got %b expected %b", c, bus.lcd_rs, rs); end
            end
         end

         if (o == 14)      bus.lcd_db_in = hi_n[j];
         else if (o == 76) bus.lcd_db_in = lo_n[j];
         else              bus.lcd_db_in = 4'($urandom);
         bus.read_enable = 1'($urandom);
         bus.read_rs     = 1'($urandom);
         bus.read_poll   = 1'($urandom);
         if (c == last) bus.read_enable = keep_en;
         if (abort_at != 0 && c == abort_at) begin
            reset = 1'b0;
            bus.read_enable = 1'b0;
            exp_rd = '0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.read_enable = 1'b0;
      bus.read_rs = 1'b0;
      bus.read_poll = 1'b0;
      bus.lcd_db_in = 4'h0;
      exp_rd = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks += 6;
         if (bus.lcd_e !== 1'b0)      begin errors++; $display("FAIL reset_e: got %b expected 0", bus.lcd_e); end
         if (bus.lcd_rs !== 1'b0)     begin errors++; $display("FAIL reset_rs: got %b expected 0", bus.lcd_rs); end
         if (bus.lcd_rw !== 1'b0)     begin errors++; $display("FAIL reset_rw: got %b expected 0", bus.lcd_rw); end
         if (bus.bus_req !== 1'b0)    begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus.bus_req); end
         if (bus.read_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", bus.read_done); end
         if (bus.read_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.read_data); end
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_rs0_read();
      int dc;
      hi_n[0] = 4'h8; lo_n[0] = 4'h3;
      hi_n[1] = 4'h0; lo_n[1] = 4'h0; hi_n[2] = 4'h0; lo_n[2] = 4'h0;
      run_read(1'b0, 1'b0, 1'b0, 0, 0, dc);
      checks += 2;
      if (dc != 79) begin errors++; $display("FAIL rs0_done_cycle: got %0d expected 79", dc); end
      if (bus.read_data !== 8'h83) begin errors++; $display("FAIL rs0_data: got %h expected 83", bus.read_data); end
   endtask

   task automatic test_rs1_read();
      int dc;
      hi_n[0] = 4'h4; lo_n[0] = 4'h1;
      run_read(1'b1, 1'b1, 1'b0, 0, 0, dc);
      checks += 2;
      if (dc != 79) begin errors++; $display("FAIL rs1_done_cycle: got %0d expected 79", dc); end
      if (bus.read_data !== 8'h41) begin errors++; $display("FAIL rs1_data: got %h expected 41", bus.read_data); end
   endtask

   task automatic test_random_reads();
      int dc;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 3; i++) begin
            hi_n[i] = 4'($urandom);
            lo_n[i] = 4'($urandom);
         end
         hi_n[2][3] = 1'b0;
         run_read(1'($urandom), 1'($urandom), 1'b0, 0, 0, dc);
         checks++;
         if (dc < 79) begin errors++; $display("FAIL random_done_seen read %0d: got %0d expected >=79", k, dc); end
      end
   endtask

   task automatic test_abort();
      int dc;
      hi_n[0] = 4'hA; lo_n[0] = 4'h5;
      run_read(1'b1, 1'b0, 1'b0, 30, 1, dc);
      checks++;
      if (dc != -1) begin errors++; $display("FAIL abort_no_done: got %0d expected -1", dc); end
      hi_n[0] = 4'h6; lo_n[0] = 4'hC;
      run_read(1'b0, 1'b0, 1'b0, 70, 3, dc);
      hi_n[0] = 4'h2; lo_n[0] = 4'h9;
      run_read(1'b0, 1'b0, 1'b0, 0, 0, dc);
      checks += 2;
      if (dc != 79) begin errors++; $display("FAIL after_reset_done_cycle: got %0d expected 79", dc); end
      if (bus.read_data !== 8'h29) begin errors++; $display("FAIL after_reset_data: got %h expected 29", bus.read_data); end
   endtask

   task automatic test_poll();
      int dc, exp_dc;
      logic exp_b7;
      hi_n[0] = {1'b1, 3'($urandom)}; lo_n[0] = 4'($urandom);
      hi_n[1] = {1'b1, 3'($urandom)}; lo_n[1] = 4'($urandom);
      hi_n[2] = {1'b0, 3'($urandom)}; lo_n[2] = 4'($urandom);
`ifdef LCD_BUSY_POLL_EN
      exp_dc = 335; exp_b7 = 1'b0;
`else
      exp_dc = 79;  exp_b7 = 1'b1;
`endif
      run_read(1'b0, 1'b1, 1'b0, 0, 0, dc);
      checks += 2;
      if (dc != exp_dc) begin errors++; $display("FAIL poll_done_cycle: got %0d expected %0d", dc, exp_dc); end
      if (bus.read_data[7] !== exp_b7) begin errors++; $display("FAIL poll_busy_bit: got %b expected %b", bus.read_data[7], exp_b7); end
   endtask

   task automatic test_back_to_back();
      int dc1, dc2;
      hi_n[0] = 4'h7; lo_n[0] = 4'hE;
      run_read(1'b1, 1'b0, 1'b1, 0, 0, dc1);
      hi_n[0] = 4'hB; lo_n[0] = 4'h4;
      run_read(1'b0, 1'b0, 1'b0, 0, 0, dc2);
      checks += 3;
      if (dc1 != 79) begin errors++; $display("FAIL b2b_first_done: got %0d expected 79", dc1); end
      if (dc2 != 79) begin errors++; $display("FAIL b2b_second_done: got %0d expected 79", dc2); end
      if (bus.read_data !== 8'hB4) begin errors++; $display("FAIL b2b_data: got %h expected b4", bus.read_data); end
   endtask

   initial begin
      test_reset();
      test_rs0_read();
      test_rs1_read();
      test_random_reads();
      test_abort();
      test_poll();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_read_fsm.md
# lcd_read_fsm

Read-side controller for the character LCD's 4-bit HD44780-style interface: it performs one RW=1 read cycle, either the busy-flag/address register (RS=0) or data RAM (RS=1), as two E-strobed nibble transfers and returns the assembled byte. It sits beside the init and instruction-write FSMs under the LCD top level. The top level uses `bus_req` to give this block the LCD pins and to tri-state the FPGA data drivers. With polling compiled in, it replaces fixed post-command waits by spinning on the busy flag.

## Interface
Parameters:
- SETUP_CYC, 2: cycles RS/RW are stable before each E rise (40 ns at 50 MHz).
- E_HIGH_CYC, 12: E high width per nibble (240 ns).
- NIBBLE_GAP_CYC, 50: E low between nibbles (1 µs).
- HOLD_CYC, 2: RS/RW hold after the final E fall.
- POLL_GAP_CYC, 50: idle between poll iterations (only used with polling).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- read_enable  in  1  request; level, sampled only in IDLE.
- read_rs  in  1  register select, captured at accept: 0 = busy flag/address, 1 = data RAM.
- read_poll  in  1  captured at accept; repeat until busy flag clear (see Configuration).
- lcd_db_in  in  4  LCD DB7..DB4 from the pads.
- lcd_e  out  1  enable strobe.
- lcd_rs  out  1  register select to the LCD.
- lcd_rw  out  1  1 = read.
- bus_req  out  1  high in every state except IDLE; top level muxes LCD pins to this block and disables DB output drivers.
- read_data  out  8  last assembled byte.
- read_done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SETUP, E_HI1, GAP, E_HI2, HOLD, POLL_WAIT, DONE. All outputs are registered.
- IDLE: if read_enable=1, capture read_rs and read_poll, clear the counter, go to SETUP.
- SETUP: lcd_rs = captured RS, lcd_rw=1, lcd_e=0 for SETUP_CYC, then go to E_HI1.
- E_HI1: lcd_e=1 for E_HIGH_CYC. In the last cycle, sample lcd_db_in into read_data[7:4]. Then go to GAP.
- GAP: lcd_e=0 for NIBBLE_GAP_CYC, then go to E_HI2.
- E_HI2: lcd_e=1 for E_HIGH_CYC. In the last cycle, sample lcd_db_in into read_data[3:0]. Then go to HOLD.
- HOLD: lcd_e=0 for HOLD_CYC; RS/RW are held. Then go to DONE, or to POLL_WAIT if the poll condition holds.
- DONE: read_done=1 for one cycle, then IDLE. The requester drops read_enable combinationally on read_done. If read_enable is still high in IDLE, a new read starts.
- Counter: 6 bits, counts the cycles spent in the current state and clears on every transition.
- In IDLE: lcd_e=0, lcd_rw=0, lcd_rs=0, bus_req=0.
- read_data holds its value between reads. Each nibble write updates it, including intermediate poll reads.

## Timing
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, bus_req=0, read_done=0, read_data=8'h00, state=IDLE.
- Cycle numbering: the accept cycle (IDLE with read_enable=1) is cycle 0.
  - SETUP: cycles 1–2.
  - E_HI1: cycles 3–14; upper nibble sampled at cycle 14.
  - GAP: cycles 15–64.
  - E_HI2: cycles 65–76; lower nibble sampled at cycle 76.
  - HOLD: cycles 77–78.
  - read_done: cycle 79.
- Reset mid-operation: the next cycle is IDLE with reset values, so E drops immediately. No read_done is issued and read_data is cleared.
- read_enable changes outside IDLE are ignored.

## Configuration
- LCD_BUSY_POLL_EN defined:
  - In HOLD, if captured read_poll=1 and captured RS=0 and read_data[7]=1, go to POLL_WAIT for POLL_GAP_CYC, then to SETUP and repeat.
  - read_done is issued only after a read with bit7=0.
  - Each iteration adds 128 cycles.
- Undefined: read_poll is ignored and every request performs exactly one read; POLL_WAIT is unreachable and may be removed.

## Structure
- Shared package lcd_pkg holds:
  - the state encoding for this block;
  - the timing constants (setup, E width, nibble gap, hold, poll gap) in 50 MHz cycles, shared with the write-side FSMs;
  - the RS select constants.
- No sub-module: the counter and FSM are inline, about 200 lines.

## Test plan
- Reset: hold reset=0 for 3 cycles mid-stream → all outputs at reset values; a subsequent read completes normally.
- RS=0 read: lcd_db_in=4'h8 around cycle 14, 4'h3 around cycle 76 → read_data=8'h83, read_done only at cycle 79, lcd_e high exactly cycles 3–14 and 65–76, lcd_rw=1 for cycles 1–78.
- RS=1 read, nibbles 4'h4/4'h1 → lcd_rs=1 for cycles 1–78, read_data=8'h41.
- Abort: assert reset at cycle 30 (GAP) → lcd_e=0, bus_req=0 next cycle, no read_done, read_data=8'h00.
- Poll (LCD_BUSY_POLL_EN): first nibble 4'h8 on two reads, then 4'h0 → a single read_done at cycle 335 with read_data[7]=0. Without the macro, the same stimulus gives read_done at cycle 79 with read_data[7]=1.
- Back-to-back: read_enable held high through read_done → the second read is accepted the cycle after DONE and lcd_e rises 3 cycles later.
